wptr_afull: RTL and testbench
=============================

WPTR_AFULL -- requirements
Module: wptr_afull

Interface
REQ-001 The block SHALL take parameter ADDRSIZE, default 4, meaning FIFO address width (DEPTH = 2**ADDRSIZE words, pointers ADDRSIZE+1 bits).
REQ-002 The block SHALL take parameter AFULL_RESET, default 2**ADDRSIZE - 2, meaning the reset value of the internal almost-full threshold register.
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 wrst_n  input  1  reset, asynchronous and active-low.
REQ-005 winc  input  1  write request for the current cycle.
REQ-006 wq2_rptr  input  ADDRSIZE+1  read pointer, Gray-coded, already synchronised into wclk.
REQ-007 thr_we  input  1  load strobe for the almost-full threshold.
REQ-008 thr_wdata  input  ADDRSIZE+1  new almost-full threshold value.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 wptr  output  ADDRSIZE+1  registered Gray write pointer for synchronisation into the read domain.
REQ-011 waddr  output  ADDRSIZE  binary RAM write address.
REQ-012 wfull  output  1  registered FIFO-full flag.
REQ-013 wafull  output  1  registered almost-full flag.
REQ-014 wcount  output  ADDRSIZE+1  registered fill level as seen from the write domain, range 0..DEPTH.
REQ-015 wovf  output  1  sticky overflow flag.

Function
REQ-016 An accepted write SHALL be winc & ~wfull; a write attempted while wfull=1 SHALL leave the pointers unchanged.
REQ-017 The next binary pointer wbnext SHALL be wbin + accepted write, wrapping modulo 2**(ADDRSIZE+1).
REQ-018 The next Gray pointer wgnext SHALL be (wbnext >> 1) ^ wbnext; wbin and wptr SHALL both register on the same edge.
REQ-019 waddr SHALL equal wbin[ADDRSIZE-1:0].
REQ-020 The block SHALL convert wq2_rptr to binary rbin_s combinationally (bit i = XOR of Gray bits ADDRSIZE..i).
REQ-021 The next fill level SHALL be diff = wbnext - rbin_s modulo 2**(ADDRSIZE+1), and wcount SHALL register diff each cycle.
REQ-022 wfull SHALL register (diff == DEPTH), which is equivalent to wgnext equalling wq2_rptr with its two MSBs inverted.
REQ-023 wafull SHALL register (diff >= thr); thr=0 SHALL hold wafull at 1, and thr > DEPTH SHALL hold wafull at 0.
REQ-024 wfull, wafull, wcount and wptr SHALL all reflect the same edge's wbnext; there is no extra latency between them.
REQ-025 A wq2_rptr advance SHALL be reflected in wcount, wfull and wafull on the next rising edge.
REQ-026 thr SHALL load thr_wdata on thr_we, and the new value SHALL take effect on the flag computed at the edge after the load.
REQ-027 wovf SHALL set on a cycle with winc=1 and wfull=1, clear on ovf_clr=1, and set SHALL win over a simultaneous clear.
REQ-028 Wrap-around of both pointers past 2**(ADDRSIZE+1)-1 SHALL produce no spurious wfull, wafull or wcount glitch.

Reset
REQ-029 While wrst_n=0, wbin, wptr, waddr, wcount, wfull, wafull and wovf SHALL be 0, and thr SHALL be AFULL_RESET.
REQ-030 Reset asserted mid-operation SHALL take effect immediately without a clock; the first write after deassertion SHALL go to waddr 0.
REQ-031 On the first edge after deassertion with wq2_rptr=0, wafull SHALL be 1 only if thr=0.

Structure
REQ-032 A shared package SHALL hold the default ADDRSIZE, a DEPTH helper function, and the gray2bin/bin2gray functions used by both pointer blocks.
REQ-033 The Gray-to-binary converter SHALL be a sub-module named gray2bin, parametrised by width and purely combinational.
REQ-034 The block SHALL contain no multi-clock logic; the synchroniser remains external.

Verification (ADDRSIZE=4, DEPTH=16, AFULL_RESET=14)
REQ-035 Reset, then 16 writes with wq2_rptr=0 -> waddr 0..15, wcount reaches 16, wafull rises after write 14, wfull=1 after write 16, wptr=5'b11000.
REQ-036 From full, drive winc=1 for 3 cycles -> wptr unchanged and wovf=1; then ovf_clr=1 -> wovf=0 the next cycle; winc and ovf_clr together -> wovf stays 1.
REQ-037 Advance wq2_rptr through Gray codes from 0 to 8 while full -> wcount steps 16..8, wfull clears one edge after the first advance, and wafull clears when wcount < 14.
REQ-038 Load thr=5 with thr_we at wcount=4, then write once -> wafull=1 on that edge; load thr=0 -> wafull=1; load thr=17 -> wafull=0 even when full.
REQ-039 Run 100 random write/read-advance cycles across two pointer wraps -> wcount always equals the scoreboard fill level and wfull equals (wcount==16).
REQ-040 Assert wrst_n low mid-burst at wcount=9 -> all outputs read 0 and thr=14 asynchronously, before the next wclk edge.

Source files
------------

// File: rtl/wptr_afull_pkg.sv
// Shared definitions for the FIFO pointer blocks: default address width,
// depth helper and Gray/binary conversion functions.
package wptr_afull_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;

    function automatic int depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_afull_gray2bin.sv
// Purely combinational Gray-to-binary converter of parametrised width.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_afull.sv
// Write-domain pointer and flag logic of an async FIFO: Gray/binary write
// pointers, fill level, full/almost-full flags and a sticky overflow flag.
module wptr_afull
    import wptr_afull_pkg::*;
#(
    parameter int ADDRSIZE    = ADDRSIZE_DEFAULT,
    parameter int AFULL_RESET = depth(ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                thr_we,
    input  logic [ADDRSIZE:0]   thr_wdata,
    input  logic                ovf_clr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] FULL_LEVEL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [31:0]       THR_INIT32 = AFULL_RESET;
    localparam logic [ADDRSIZE:0] THR_INIT   = THR_INIT32[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbnext;
    logic [ADDRSIZE:0] wgnext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] diff;
    logic [ADDRSIZE:0] thr;
    logic              wr_accept;

    gray2bin #(.WIDTH(PW)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Flags are computed from the post-increment pointer so they land on the
    // same edge as the pointer itself.
    always_comb begin
        wr_accept = winc & ~wfull;
        wbnext    = wbin + {{ADDRSIZE{1'b0}}, wr_accept};
        wgnext    = PW'(bin2gray(32'(wbnext)));
        diff      = wbnext - rbin_s;
    end

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wcount <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
        end else begin
            wbin   <= wbnext;
            wptr   <= wgnext;
            wcount <= diff;
            wfull  <= (diff == FULL_LEVEL);
            wafull <= (diff >= thr);
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            thr <= THR_INIT;
        end else if (thr_we) begin
            thr <= thr_wdata;
        end
    end

    // A rejected write outranks a clear so no overflow event is ever lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (ovf_clr) begin
            wovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_afull.sv
// Directed self-checking bench for wptr_afull with ADDRSIZE=4.
module tb_wptr_afull;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       thr_we;
    logic [4:0] thr_wdata;
    logic       ovf_clr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wcount;
    logic       wovf;

    int n_checks = 0;
    int n_fail   = 0;

    wptr_afull #(.ADDRSIZE(4), .AFULL_RESET(14)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .wq2_rptr  (wq2_rptr),
        .thr_we    (thr_we),
        .thr_wdata (thr_wdata),
        .ovf_clr   (ovf_clr),
        .wptr      (wptr),
        .waddr     (waddr),
        .wfull     (wfull),
        .wafull    (wafull),
        .wcount    (wcount),
        .wovf      (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; winc = 0; wq2_rptr = '0; thr_we = 0; thr_wdata = '0; ovf_clr = 0;
        tick(); tick();
        n_checks++;
        if ({wptr, waddr, wcount, wfull, wafull, wovf} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got wptr=%0d waddr=%0d wcount=%0d wfull=%0d wafull=%0d wovf=%0d, want all 0",
                     wptr, waddr, wcount, wfull, wafull, wovf);
        end
        n_checks++;
        if (dut.thr !== 5'd14) begin
            n_fail++;
            $display("[TB] FAIL reset_thr: got %0d want 14", dut.thr);
        end
        wrst_n = 1'b1;
        tick();
        n_checks++;
        if (wafull !== 1'b0 || wcount !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL first_edge: got wafull=%0d wcount=%0d want 0 0", wafull, wcount);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (waddr !== 4'(i)) begin
                n_fail++;
                $display("[TB] FAIL fill_waddr: got %0d want %0d", waddr, i);
            end
            winc = 1'b1;
            tick();
            n_checks++;
            if (wcount !== 5'(i + 1) || wafull !== (i + 1 >= 14) || wfull !== (i + 1 == 16)) begin
                n_fail++;
                $display("[TB] FAIL fill_step%0d: got wcount=%0d wafull=%0d wfull=%0d want %0d %0d %0d",
                         i, wcount, wafull, wfull, i + 1, (i + 1 >= 14), (i + 1 == 16));
            end
        end
        winc = 1'b0;
        n_checks++;
        if (wptr !== 5'b11000) begin
            n_fail++;
            $display("[TB] FAIL fill_wptr: got %b want 11000", wptr);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (wptr !== 5'b11000 || wovf !== 1'b1 || wcount !== 5'd16) begin
                n_fail++;
                $display("[TB] FAIL ovf_write%0d: got wptr=%b wovf=%0d wcount=%0d want 11000 1 16",
                         i, wptr, wovf, wcount);
            end
        end
        winc = 1'b0; ovf_clr = 1'b1;
        tick();
        n_checks++;
        if (wovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_clear: got %0d want 0", wovf);
        end
        winc = 1'b1;
        tick();
        n_checks++;
        if (wovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_set_wins: got %0d want 1", wovf);
        end
        winc = 1'b0;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (wovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_reclear: got %0d want 0", wovf);
        end
    endtask

    task automatic test_read_advance();
        for (int r = 1; r <= 8; r++) begin
            wq2_rptr = gray5(r);
            tick();
            n_checks++;
            if (wcount !== 5'(16 - r) || wfull !== 1'b0 || wafull !== (16 - r >= 14)) begin
                n_fail++;
                $display("[TB] FAIL read_adv%0d: got wcount=%0d wfull=%0d wafull=%0d want %0d 0 %0d",
                         r, wcount, wfull, wafull, 16 - r, (16 - r >= 14));
            end
        end
    endtask

    task automatic test_threshold();
        for (int r = 9; r <= 12; r++) begin
            wq2_rptr = gray5(r);
            tick();
        end
        thr_we = 1'b1; thr_wdata = 5'd5;
        tick();
        thr_we = 1'b0;
        n_checks++;
        if (wcount !== 5'd4 || wafull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL thr5_load: got wcount=%0d wafull=%0d want 4 0", wcount, wafull);
        end
        winc = 1'b1;
        tick();
        winc = 1'b0;
        n_checks++;
        if (wcount !== 5'd5 || wafull !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL thr5_write: got wcount=%0d wafull=%0d want 5 1", wcount, wafull);
        end
        thr_we = 1'b1; thr_wdata = 5'd0;
        tick();
        thr_we = 1'b0;
        for (int r = 13; r <= 17; r++) begin
            wq2_rptr = gray5(r);
            tick();
        end
        n_checks++;
        if (wcount !== 5'd0 || wafull !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL thr0_empty: got wcount=%0d wafull=%0d want 0 1", wcount, wafull);
        end
        thr_we = 1'b1; thr_wdata = 5'd17;
        tick();
        thr_we = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        winc = 1'b0;
        n_checks++;
        if (wcount !== 5'd16 || wfull !== 1'b1 || wafull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL thr17_full: got wcount=%0d wfull=%0d wafull=%0d want 16 1 0",
                     wcount, wfull, wafull);
        end
        thr_we = 1'b1; thr_wdata = 5'd14;
        tick();
        thr_we = 1'b0;
    endtask

    task automatic test_random();
        int  wb;
        int  rb;
        int  cnt;
        bit  exp_full;
        bit  w;
        bit  rd;
        wb = 1; rb = 17; exp_full = 1'b1;
        for (int c = 0; c < 100; c++) begin
            w  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 9) < 7) && (((wb - rb) & 31) != 0);
            if (rd) rb = (rb + 1) & 31;
            winc     = w;
            wq2_rptr = gray5(rb);
            if (w && !exp_full) wb = (wb + 1) & 31;
            tick();
            cnt      = (wb - rb) & 31;
            exp_full = (cnt == 16);
            n_checks++;
            if (wcount !== 5'(cnt) || wfull !== exp_full) begin
                n_fail++;
                $display("[TB] FAIL random_c%0d: got wcount=%0d wfull=%0d want %0d %0d",
                         c, wcount, wfull, cnt, exp_full);
            end
            n_checks++;
            if (wfull !== (wcount == 5'd16)) begin
                n_fail++;
                $display("[TB] FAIL random_fullrel%0d: got wfull=%0d with wcount=%0d", c, wfull, wcount);
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_async_reset();
        wrst_n = 1'b0; winc = 0; wq2_rptr = '0;
        tick();
        wrst_n = 1'b1;
        thr_we = 1'b1; thr_wdata = 5'd3;
        tick();
        thr_we = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (wcount !== 5'd9 || wafull !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL burst_level: got wcount=%0d wafull=%0d want 9 1", wcount, wafull);
        end
        #2;
        wrst_n = 1'b0;
        #1;
        n_checks++;
        if ({wptr, waddr, wcount, wfull, wafull, wovf} !== 17'd0 || dut.thr !== 5'd14) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got wptr=%0d waddr=%0d wcount=%0d wfull=%0d wafull=%0d wovf=%0d thr=%0d, want 0s thr 14",
                     wptr, waddr, wcount, wfull, wafull, wovf, dut.thr);
        end
        winc = 1'b0;
        tick();
        wrst_n = 1'b1;
        n_checks++;
        if (waddr !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_waddr: got %0d want 0", waddr);
        end
        winc = 1'b1;
        tick();
        winc = 1'b0;
        n_checks++;
        if (wcount !== 5'd1 || waddr !== 4'd1 || wptr !== 5'b00001) begin
            n_fail++;
            $display("[TB] FAIL post_reset_write: got wcount=%0d waddr=%0d wptr=%b want 1 1 00001",
                     wcount, waddr, wptr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_advance();
        test_threshold();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
